score_display_scheduler: RTL and testbench
==========================================

Name: score_display_scheduler

Overview:
- Sequences the shared two-digit score decoder (8-bit value in, two 7-seg digit codes out) between player score, dealer score and the most recently dealt card.
- Rotates player and dealer on a dwell timer.
- Preempts the rotation to show a newly dealt card for a hold period.
- Flashes the player score while bust is asserted.
- Sits between the game FSM and the decoder on the board top level.

Parameters:
- DWELL, 50000000, cycles each score is shown during rotation (1 s at 50 MHz)
- CARD_HOLD, 100000000, cycles a new card is shown before rotation resumes
- FLASH_HALF, 12500000, cycles per blank/unblank half-period in bust flash
- CNT_W, 27, timer width; must hold max(DWELL, CARD_HOLD) - 1

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  timer advance enable; low freezes all timers
- player_score  in  5  player hand total, 0..31
- dealer_score  in  5  dealer hand total, 0..31
- card_value  in  5  value of card being dealt; valid when new_card=1
- new_card  in  1  single-cycle pulse: card dealt
- bust  in  1  level: player bust
- disp_value  out  8  value to decoder, {3'b000, selected 5-bit source}
- disp_src  out  2  00 player, 01 dealer, 10 card, 11 unused
- disp_blank  out  1  1 = decoder outputs to be forced off by top level
- card_ack  out  1  single-cycle pulse: card latched

Behaviour:
- Reset (async, resetn=0):
  - state SHOW_P, timer 0, card_reg 0, ret_state SHOW_P.
  - disp_value 0, disp_src 00, disp_blank 0, card_ack 0.
  - Takes effect immediately, including mid-hold or mid-flash.
- All outputs are registered. Inputs sampled at edge N appear on outputs after edge N (1-cycle latency).
- States and rules:
  - SHOW_P: disp_src 00, disp_value tracks player_score every cycle. When enable=1, timer increments. At timer==DWELL-1 with enable=1: go to SHOW_D, timer 0.
  - SHOW_D: same as SHOW_P with dealer_score and disp_src 01. Expiry goes to SHOW_P.
  - Entry to SHOW_CARD: new_card=1 in SHOW_P or SHOW_D. Latch card_value into card_reg, ret_state := current state, timer 0, card_ack=1 for one cycle.
  - SHOW_CARD: disp_src 10, disp_value shows card_reg only; later card_value changes are ignored.
    - new_card again: relatch card_reg, restart timer, pulse card_ack. ret_state is unchanged.
    - At timer==CARD_HOLD-1 with enable=1: go to ret_state, timer 0.
  - BUST_FLASH: entered from any state when bust=1, timer 0, disp_blank 0 on entry.
    - disp_src 00, disp_value tracks player_score.
    - disp_blank toggles each time timer reaches FLASH_HALF-1 with enable=1; timer then wraps to 0.
    - new_card is dropped: no latch, no ack.
    - bust=0: go to SHOW_P, timer 0, disp_blank 0.
- Priority: bust > new_card > timer expiry.
- Simultaneous events:
  - new_card coincident with dwell expiry: go to SHOW_CARD, with ret_state = state at arrival (pre-expiry). That state's dwell restarts from 0 on return.
  - bust coincident with new_card: go to BUST_FLASH; card dropped, card_ack 0.
- enable=0:
  - Timers and flash phase hold.
  - new_card and bust are still processed; card_ack still pulses.
- Widths:
  - Timer compares are on the full CNT_W value.
  - disp_value upper 3 bits are always 0.
  - disp_blank is 0 in every state except BUST_FLASH.

Test Plan (DWELL=4, CARD_HOLD=6, FLASH_HALF=2):
- Reset and rotation: resetn pulse, player_score=17, dealer_score=9, enable=1 -> outputs 0/00/0 during reset; after release disp_value=17 src 00; after 4 edges src 01 value 9; 4 more back to src 00 value 17.
- Card preempt: in SHOW_D at timer 2, new_card with card_value=10, then card_value=3 -> next edge src 10, value 10, card_ack high 1 cycle; value stays 10 for 6 cycles, then src 01 value 9 with full 4-cycle dwell.
- Bust flash: bust=1 during SHOW_CARD, player_score=23 -> src 00, value 23; disp_blank sequence 0,0,1,1,0,0; new_card during flash gives card_ack=0; bust=0 -> SHOW_P, blank 0.
- Freeze: enable=0 for 10 cycles in SHOW_P at timer 3 -> no transition; enable=1 -> src 01 after 1 edge. A new_card while frozen still acks and shows the card.
- Async reset mid-hold: resetn low in SHOW_CARD between edges -> outputs 0/00/0 immediately without waiting for a clock edge; after release, SHOW_P rotation from timer 0.
- Coincidence: new_card on the edge where SHOW_P dwell expires -> SHOW_CARD, returns to SHOW_P (not SHOW_D) after 6 cycles.

Source files
------------

// File: rtl/score_display_scheduler.sv
// Purpose : time-shares the two-digit score decoder between player score, dealer score and the last dealt card.
// Latency : 1 cycle; inputs sampled at edge N appear on the outputs after edge N.
// Backpress: none; new_card is never stalled (card_ack confirms the latch), and it is dropped while bust is high.
//
// Ports:
//   clk, resetn        - system clock, asynchronous active-low reset
//   enable             - advances dwell/hold/flash timers; low freezes them (events still handled)
//   player_score [4:0] - player hand total
//   dealer_score [4:0] - dealer hand total
//   card_value   [4:0] - card being dealt, qualified by new_card
//   new_card           - single-cycle pulse announcing a dealt card
//   bust               - level, player is bust; forces flashing player score
//   disp_value   [7:0] - value for the decoder, upper 3 bits always 0
//   disp_src     [1:0] - 00 player, 01 dealer, 10 card
//   disp_blank         - ask the top level to force the decoder outputs off
//   card_ack           - single-cycle pulse, card_value has been latched
module score_display_scheduler #(
  parameter int DWELL      = 50000000,
  parameter int CARD_HOLD  = 100000000,
  parameter int FLASH_HALF = 12500000,
  parameter int CNT_W      = 27
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [4:0] player_score,
  input  logic [4:0] dealer_score,
  input  logic [4:0] card_value,
  input  logic       new_card,
  input  logic       bust,
  output logic [7:0] disp_value,
  output logic [1:0] disp_src,
  output logic       disp_blank,
  output logic       card_ack
);

  typedef enum logic [1:0] {
    SHOW_P     = 2'b00,
    SHOW_D     = 2'b01,
    SHOW_CARD  = 2'b10,
    BUST_FLASH = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CARD_HOLD - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [4:0]       card_q, card_d;
  logic [4:0]       val_q, val_d;
  logic [1:0]       src_q, src_d;
  logic             blank_q, blank_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] last_cnt;

  // Next state. Priority is bust, then new_card, then timer expiry.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    timer_d  = timer_q;
    card_d   = card_q;
    blank_d  = 1'b0;
    ack_d    = 1'b0;
    last_cnt = (state_q == SHOW_CARD) ? HOLD_LAST : DWELL_LAST;

    if (bust) begin
      state_d = BUST_FLASH;
      if (state_q != BUST_FLASH) begin
        // Fresh entry: flash phase starts unblanked from timer 0.
        timer_d = '0;
      end else begin
        blank_d = blank_q;
        if (enable) begin
          if (timer_q == FLASH_LAST) begin
            timer_d = '0;
            blank_d = ~blank_q;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
    end else if (state_q == BUST_FLASH) begin
      state_d = SHOW_P;
      timer_d = '0;
    end else if (new_card) begin
      // A relatch inside SHOW_CARD keeps the original return state.
      state_d = SHOW_CARD;
      card_d  = card_value;
      timer_d = '0;
      ack_d   = 1'b1;
      if (state_q != SHOW_CARD) begin
        ret_d = state_q;
      end
    end else if (enable) begin
      if (timer_q == last_cnt) begin
        timer_d = '0;
        case (state_q)
          SHOW_P:    state_d = SHOW_D;
          SHOW_D:    state_d = SHOW_P;
          SHOW_CARD: state_d = ret_q;
          default:   state_d = SHOW_P;
        endcase
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end
  end

  // Output selection follows the state being entered so every output is a register.
  always_comb begin
    src_d = 2'b00;
    val_d = player_score;
    case (state_d)
      SHOW_D: begin
        src_d = 2'b01;
        val_d = dealer_score;
      end
      SHOW_CARD: begin
        src_d = 2'b10;
        val_d = card_d;
      end
      default: begin
        src_d = 2'b00;
        val_d = player_score;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SHOW_P;
      ret_q   <= SHOW_P;
      timer_q <= '0;
      card_q  <= '0;
      val_q   <= '0;
      src_q   <= 2'b00;
      blank_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      timer_q <= timer_d;
      card_q  <= card_d;
      val_q   <= val_d;
      src_q   <= src_d;
      blank_q <= blank_d;
      ack_q   <= ack_d;
    end
  end

  assign disp_value = {3'b000, val_q};
  assign disp_src   = src_q;
  assign disp_blank = blank_q;
  assign card_ack   = ack_q;

endmodule

// File: tb/tb_score_display_scheduler.sv
// Purpose : directed plus random stimulus for score_display_scheduler against a countdown-based reference model.
// Latency : checks outputs 1 ns after each rising edge.
// Backpress: not applicable.
module tb_score_display_scheduler;

  localparam int DWELL      = 4;
  localparam int CARD_HOLD  = 6;
  localparam int FLASH_HALF = 2;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [4:0] player_score;
  logic [4:0] dealer_score;
  logic [4:0] card_value;
  logic       new_card;
  logic       bust;
  logic [7:0] disp_value;
  logic [1:0] disp_src;
  logic       disp_blank;
  logic       card_ack;

  int tests_run;
  int tests_failed;

  // Reference model: mode 0 player, 1 dealer, 2 card, 3 bust flash.
  // m_left counts enabled edges still to go before the current phase ends.
  int         m_mode;
  int         m_left;
  int         m_ret;
  logic [4:0] m_card;
  logic       m_blank;
  logic [4:0] exp_val;
  logic [1:0] exp_src;
  logic       exp_blank;
  logic       exp_ack;

  score_display_scheduler #(
    .DWELL(DWELL),
    .CARD_HOLD(CARD_HOLD),
    .FLASH_HALF(FLASH_HALF),
    .CNT_W(27)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .player_score(player_score),
    .dealer_score(dealer_score),
    .card_value(card_value),
    .new_card(new_card),
    .bust(bust),
    .disp_value(disp_value),
    .disp_src(disp_src),
    .disp_blank(disp_blank),
    .card_ack(card_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_left    = DWELL;
    m_ret     = 0;
    m_card    = '0;
    m_blank   = 1'b0;
    exp_val   = '0;
    exp_src   = 2'b00;
    exp_blank = 1'b0;
    exp_ack   = 1'b0;
  endtask

  task automatic model_step();
    exp_ack = 1'b0;
    if (bust) begin
      if (m_mode != 3) begin
        m_mode  = 3;
        m_left  = FLASH_HALF;
        m_blank = 1'b0;
      end else if (enable) begin
        m_left--;
        if (m_left == 0) begin
          m_blank = !m_blank;
          m_left  = FLASH_HALF;
        end
      end
    end else if (m_mode == 3) begin
      m_mode  = 0;
      m_left  = DWELL;
      m_blank = 1'b0;
    end else if (new_card) begin
      if (m_mode != 2) m_ret = m_mode;
      m_mode  = 2;
      m_card  = card_value;
      m_left  = CARD_HOLD;
      exp_ack = 1'b1;
    end else if (enable) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = (m_mode == 2) ? m_ret : 1 - m_mode;
        m_left = DWELL;
      end
    end
    exp_src   = (m_mode == 3) ? 2'd0 : 2'(m_mode);
    exp_val   = (m_mode == 2) ? m_card : (m_mode == 1) ? dealer_score : player_score;
    exp_blank = (m_mode == 3) && m_blank;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/value"}, disp_value, {3'b000, exp_val});
    chk({tag, "/src"},   {6'd0, disp_src}, {6'd0, exp_src});
    chk({tag, "/blank"}, {7'd0, disp_blank}, {7'd0, exp_blank});
    chk({tag, "/ack"},   {7'd0, card_ack}, {7'd0, exp_ack});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bit blank_seq [6];
    blank_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tests_run    = 0;
    tests_failed = 0;

    resetn       = 1'b1;
    enable       = 1'b1;
    player_score = 5'd17;
    dealer_score = 5'd9;
    card_value   = 5'd0;
    new_card     = 1'b0;
    bust         = 1'b0;
    model_reset();

    // Reset and rotation
    #1 resetn = 1'b0;
    #1 check_outputs("reset_async");
    cycle("reset_hold");
    cycle("reset_hold");
    resetn = 1'b1;
    cycle("rot_first");
    chk("rot_first_val", disp_value, 8'd17);
    cycle("rot");
    cycle("rot");
    cycle("rot_to_d");
    chk("rot_to_d_src", {6'd0, disp_src}, 8'd1);
    chk("rot_to_d_val", disp_value, 8'd9);
    for (int i = 0; i < 4; i++) cycle("rot_d");
    chk("rot_back_p_src", {6'd0, disp_src}, 8'd0);
    chk("rot_back_p_val", disp_value, 8'd17);

    // Card preempt from SHOW_D at timer 2
    for (int i = 0; i < 6; i++) cycle("pre_card");
    new_card   = 1'b1;
    card_value = 5'd10;
    cycle("card_entry");
    chk("card_entry_ack", {7'd0, card_ack}, 8'd1);
    chk("card_entry_val", disp_value, 8'd10);
    new_card   = 1'b0;
    card_value = 5'd3;
    for (int i = 0; i < 5; i++) cycle("card_hold");
    chk("card_hold_val", disp_value, 8'd10);
    cycle("card_return");
    chk("card_return_src", {6'd0, disp_src}, 8'd1);
    chk("card_return_val", disp_value, 8'd9);
    for (int i = 0; i < 3; i++) cycle("ret_dwell");
    chk("ret_dwell_src", {6'd0, disp_src}, 8'd1);
    cycle("ret_dwell_end");
    chk("ret_dwell_end_src", {6'd0, disp_src}, 8'd0);

    // Bust flash entered from SHOW_CARD
    new_card   = 1'b1;
    card_value = 5'd5;
    cycle("card_b");
    new_card     = 1'b0;
    player_score = 5'd23;
    bust         = 1'b1;
    for (int i = 0; i < 6; i++) begin
      new_card = (i == 2);
      cycle("flash");
      chk("flash_blank", {7'd0, disp_blank}, {7'd0, blank_seq[i]});
      chk("flash_val", disp_value, 8'd23);
    end
    chk("flash_card_drop_ack", {7'd0, card_ack}, 8'd0);
    new_card = 1'b0;
    bust     = 1'b0;
    cycle("unbust");
    chk("unbust_blank", {7'd0, disp_blank}, 8'd0);
    chk("unbust_src", {6'd0, disp_src}, 8'd0);

    // Freeze at SHOW_P timer 3
    for (int i = 0; i < 3; i++) cycle("pre_freeze");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle("frozen");
    chk("frozen_src", {6'd0, disp_src}, 8'd0);
    enable = 1'b1;
    cycle("thaw");
    chk("thaw_src", {6'd0, disp_src}, 8'd1);
    enable     = 1'b0;
    new_card   = 1'b1;
    card_value = 5'd7;
    cycle("frozen_card");
    chk("frozen_card_ack", {7'd0, card_ack}, 8'd1);
    chk("frozen_card_val", disp_value, 8'd7);
    new_card = 1'b0;
    for (int i = 0; i < 3; i++) cycle("frozen_hold");
    enable = 1'b1;

    // Asynchronous reset in the middle of a card hold
    cycle("hold_a");
    cycle("hold_b");
    #2 resetn = 1'b0;
    #1 model_reset();
    check_outputs("async_mid_hold");
    cycle("async_edge");
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");
    chk("post_rst_src", {6'd0, disp_src}, 8'd0);

    // new_card coincident with dwell expiry in SHOW_P
    new_card   = 1'b1;
    card_value = 5'd12;
    cycle("coinc");
    chk("coinc_src", {6'd0, disp_src}, 8'd2);
    new_card = 1'b0;
    for (int i = 0; i < 6; i++) cycle("coinc_hold");
    chk("coinc_ret_src", {6'd0, disp_src}, 8'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      enable       = ($urandom_range(0, 3) != 0);
      player_score = 5'($urandom_range(0, 31));
      dealer_score = 5'($urandom_range(0, 31));
      card_value   = 5'($urandom_range(0, 31));
      new_card     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) bust = ~bust;
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
